mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-to-writeback pipeline stage of the Y86-64 5-stage pipeline. It sits directly downstream of data_memory: it merges the memory-stage status with the data-memory error, and registers the memory-stage results (valE, and valM from mem_data) into the W pipeline register. It drives register-file write ports and W-stage forwarding values. It holds a sticky halt state machine that freezes the pipeline tail on the first exception.

Parameters:
- DATA_W, 64, datapath width for valE/valM.
- CNT_W, 32, width of the retired-instruction counter (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- M_stat  in  3  memory-stage status: AOK=1, HLT=2, ADR=3, INS=4.
- M_icode  in  4  memory-stage instruction code.
- M_valE  in  DATA_W  ALU result carried from execute.
- m_valM  in  DATA_W  load data from data_memory (mem_data).
- dmem_error  in  1  data-memory address error for the current M instruction.
- M_dstE  in  4  destination for valE; 0xF = RNONE.
- M_dstM  in  4  destination for valM; 0xF = RNONE.
- M_valid  in  1  M holds a real instruction, not a bubble.
- W_stall  in  1  hold the W register.
- W_bubble  in  1  load a bubble into W.
- m_stat  out  3  merged status, combinational; feeds pipeline control.
- W_stat  out  3  registered W status; also the program status.
- W_icode  out  4  registered icode.
- W_valE  out  DATA_W  registered valE; register-file port E data and forward source.
- W_valM  out  DATA_W  registered valM; register-file port M data and forward source.
- W_dstE  out  4  registered dstE.
- W_dstM  out  4  registered dstM.
- wE_en  out  1  register-file write enable, port E.
- wM_en  out  1  register-file write enable, port M.
- halted  out  1  sticky halt flag.
- retired  out  CNT_W  retired-instruction count (present only with RETIRE_CNT_EN).

Behaviour:
- Status merge: m_stat = ADR (3) when dmem_error=1; otherwise m_stat = M_stat. Purely combinational.
- Reset (rst_n=0, asynchronous):
  - W register holds a bubble: W_stat=AOK, W_icode=NOP(1), W_valE=0, W_valM=0, W_dstE=W_dstM=0xF, W_valid=0.
  - halted=0; retired=0; FSM in RUN.
- FSM states: RUN and HALTED.
  - RUN→HALTED on the rising edge where W_stat≠AOK and W_valid=1, i.e. the cycle after an exception instruction reaches W.
  - HALTED is left only by reset.
  - halted=1 exactly when the FSM is in HALTED.
- W register update on each rising edge, by priority:
  - (1) FSM in HALTED, or W_stat≠AOK with W_valid=1: hold.
  - (2) W_stall=1: hold.
  - (3) W_bubble=1: load a bubble.
  - (4) Otherwise load {m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM, M_valid}.
- W_stall and W_bubble asserted together: stall wins; simulation-only assertion flags it as an error.
- Write enables (combinational):
  - wE_en = W_valid & (W_stat==AOK) & (W_dstE≠0xF) & ~halted.
  - wM_en = W_valid & (W_stat==AOK) & (W_dstM≠0xF) & ~halted.
  - An instruction in W with HLT/ADR/INS status never writes the register file.
- Write latency: M inputs appear on W outputs one cycle after capture; the register-file write occurs in the following cycle.
- valM is captured regardless of icode; the register file ignores it through dstM=RNONE.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined:
  - retired increments by 1 on each edge that performs update case (4) with M_valid=1 and m_stat==AOK.
  - It wraps modulo 2^CNT_W.
  - It freezes in HALTED.
- Undefined: the retired port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package y86_pkg holds:
  - stat codes STAT_AOK/HLT/ADR/INS;
  - icode constants (I_HALT..I_POPQ, I_NOP=1);
  - RNONE=4'hF;
  - typedef w_reg_t bundling stat/icode/valE/valM/dstE/dstM/valid.
- One sub-module: stage_reg, a generic stall/bubble pipeline register parameterised by width and bubble value. It is reusable for the F/D/E/M registers.

Test Plan:
- Reset mid-run: drive valid traffic, pulse rst_n low asynchronously between edges → outputs immediately W_icode=1, W_dstE=W_dstM=0xF, W_valid=0, halted=0, wE_en=wM_en=0.
- Normal OPq: M_icode=6, M_valE=0x2A, M_dstE=3, dstM=0xF, M_stat=AOK, M_valid=1 → next cycle W_valE=0x2A, W_dstE=3, wE_en=1, wM_en=0.
- Load with error: M_icode=5, M_dstM=2, dmem_error=1 → m_stat=3 same cycle; next cycle W_stat=3, wM_en=0; following edge halted=1; later M inputs are ignored and W is unchanged.
- halt instruction: M_icode=0, M_stat=HLT → W_stat=2, no writes; halted=1 one edge later; W_stall/W_bubble have no effect thereafter.
- Stall then bubble: load popq (dstE=4, dstM=5); assert W_stall 2 cycles → W unchanged; assert W_bubble → W_icode=1, both dst=0xF, wE_en=wM_en=0.
- With RETIRE_CNT_EN, CNT_W=4: retire 17 valid AOK instructions, with 2 bubbles and one stall interleaved → retired=1 (wrap); bubbles and stalls do not count.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: status codes, icodes, register ids and W-register layout.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic        valid;
    } w_reg_t;

    typedef enum logic {StRun, StHalted} halt_state_e;

endpackage

// File: rtl/stage_reg.sv
// Generic pipeline register with stall (hold) and bubble (load BUBBLE) controls; stall has priority.
module stage_reg #(
    parameter int unsigned       WIDTH  = 8,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (stall) begin
            q <= q;
        end else if (bubble) begin
            q <= BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Y86-64 memory-to-writeback stage: status merge, W register, write enables, sticky halt.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module mem_wb_stage
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic              dmem_error,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              M_valid,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic [2:0]        m_stat,
    output logic [2:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic              wE_en,
    output logic              wM_en,
    output logic              halted
`ifdef RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  retired
`endif
);

    localparam int unsigned WW = 3 + 4 + 2 * DATA_W + 4 + 4 + 1;
    localparam logic [WW-1:0] W_BUBBLE =
        {STAT_AOK, I_NOP, {DATA_W{1'b0}}, {DATA_W{1'b0}}, RNONE, RNONE, 1'b0};

    logic [WW-1:0] w_d;
    logic [WW-1:0] w_q;
    logic          w_valid;
    logic          w_exc;
    logic          freeze;
    halt_state_e   state_q;
    halt_state_e   state_d;

    assign m_stat = dmem_error ? STAT_ADR : M_stat;

    assign w_d = {m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM, M_valid};
    assign {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, w_valid} = w_q;

    // An exception sitting in W freezes the tail on the same edge the FSM moves to HALTED.
    assign w_exc  = w_valid & (W_stat != STAT_AOK);
    assign freeze = halted | w_exc;

    stage_reg #(
        .WIDTH  (WW),
        .BUBBLE (W_BUBBLE)
    ) u_w_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (freeze | W_stall),
        .bubble (W_bubble),
        .d      (w_d),
        .q      (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (w_exc) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    assign halted = (state_q == StHalted);

    assign wE_en = w_valid & (W_stat == STAT_AOK) & (W_dstE != RNONE) & ~halted;
    assign wM_en = w_valid & (W_stat == STAT_AOK) & (W_dstM != RNONE) & ~halted;

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    // Counts only edges that actually load M into W with a real, non-faulting instruction.
    assign retire = ~freeze & ~W_stall & ~W_bubble & M_valid & (m_stat == STAT_AOK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;
`endif

`ifndef SYNTHESIS
    stall_bubble_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(W_stall && W_bubble))
        else $error("W_stall and W_bubble asserted together");
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_wb_stage;
    import y86_pkg::*;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        M_stat = STAT_AOK;
    logic [3:0]        M_icode = I_NOP;
    logic [DATA_W-1:0] M_valE = '0;
    logic [DATA_W-1:0] m_valM = '0;
    logic              dmem_error = 1'b0;
    logic [3:0]        M_dstE = RNONE;
    logic [3:0]        M_dstM = RNONE;
    logic              M_valid = 1'b0;
    logic              W_stall = 1'b0;
    logic              W_bubble = 1'b0;
    logic [2:0]        m_stat;
    logic [2:0]        W_stat;
    logic [3:0]        W_icode;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;
    logic              wE_en;
    logic              wM_en;
    logic              halted;
`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0]  retired;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: architectural view of the W register and halt state.
    w_reg_t exp_w;
    logic   exp_halted;
    int     exp_retired;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .M_stat     (M_stat),
        .M_icode    (M_icode),
        .M_valE     (M_valE),
        .m_valM     (m_valM),
        .dmem_error (dmem_error),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM),
        .M_valid    (M_valid),
        .W_stall    (W_stall),
        .W_bubble   (W_bubble),
        .m_stat     (m_stat),
        .W_stat     (W_stat),
        .W_icode    (W_icode),
        .W_valE     (W_valE),
        .W_valM     (W_valM),
        .W_dstE     (W_dstE),
        .W_dstM     (W_dstM),
        .wE_en      (wE_en),
        .wM_en      (wM_en),
        .halted     (halted)
`ifdef RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    function automatic w_reg_t bubble_w();
        w_reg_t b;
        b = '{stat: STAT_AOK, icode: I_NOP, val_e: '0, val_m: '0,
              dst_e: RNONE, dst_m: RNONE, valid: 1'b0};
        return b;
    endfunction

    task automatic model_reset();
        exp_w       = bubble_w();
        exp_halted  = 1'b0;
        exp_retired = 0;
    endtask

    // One clock edge in the model, from the rules: frozen > stall > bubble > capture.
    task automatic model_edge();
        logic [2:0] ms;
        logic       stopped;
        ms      = dmem_error ? STAT_ADR : M_stat;
        stopped = exp_halted || (exp_w.valid && exp_w.stat != STAT_AOK);
        if (stopped) begin
            exp_halted = 1'b1;
        end else if (W_stall) begin
            exp_w = exp_w;
        end else if (W_bubble) begin
            exp_w = bubble_w();
        end else begin
            exp_w = '{stat: ms, icode: M_icode, val_e: M_valE, val_m: m_valM,
                      dst_e: M_dstE, dst_m: M_dstM, valid: M_valid};
            if (M_valid && ms == STAT_AOK) exp_retired = (exp_retired + 1) % (1 << CNT_W);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                           input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm,
                           input logic vld, input logic err);
        M_stat = st; M_icode = ic; M_valE = ve; m_valM = vm;
        M_dstE = de; M_dstM = dm; M_valid = vld; dmem_error = err;
    endtask

    // Asserts reset between clock edges and releases it before the next edge.
    task automatic pulse_reset();
        W_stall = 1'b0; W_bubble = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (W_stat !== STAT_AOK || W_icode !== I_NOP || W_dstE !== RNONE || W_dstM !== RNONE ||
            W_valE !== '0 || W_valM !== '0 || halted !== 1'b0 || wE_en !== 1'b0 || wM_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: stat=%0d icode=%0d dstE=%h dstM=%h halted=%b wE=%b wM=%b",
                     W_stat, W_icode, W_dstE, W_dstM, halted, wE_en, wM_en);
        end
        rst_n = 1'b1;
        model_reset();
        drive_m(STAT_AOK, I_OPQ, 64'h77, 64'h88, 4'd1, 4'd2, 1'b1, 1'b0);
        tick();
        tick();
        checks++;
        if (wE_en !== 1'b1 || W_valE !== 64'h77) begin
            failures++;
            $display("FAIL reset_pre_traffic: wE=%b valE=%h required wE=1 valE=77", wE_en, W_valE);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (W_icode !== I_NOP || W_dstE !== RNONE || W_dstM !== RNONE || halted !== 1'b0 ||
            wE_en !== 1'b0 || wM_en !== 1'b0 || W_stat !== STAT_AOK || W_valE !== '0) begin
            failures++;
            $display("FAIL reset_async: icode=%0d dstE=%h dstM=%h halted=%b wE=%b wM=%b required bubble",
                     W_icode, W_dstE, W_dstM, halted, wE_en, wM_en);
        end
`ifdef RETIRE_CNT_EN
        checks++;
        if (retired !== '0) begin
            failures++;
            $display("FAIL reset_retired: got %0d required 0", retired);
        end
`endif
        rst_n = 1'b1;
        model_reset();
        drive_m(STAT_AOK, I_NOP, '0, '0, RNONE, RNONE, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_opq();
        pulse_reset();
        drive_m(STAT_AOK, I_OPQ, 64'h2A, 64'h5555, 4'd3, RNONE, 1'b1, 1'b0);
        tick();
        checks++;
        if (W_valE !== 64'h2A || W_dstE !== 4'd3 || W_icode !== I_OPQ || wE_en !== 1'b1 || wM_en !== 1'b0) begin
            failures++;
            $display("FAIL opq: valE=%h dstE=%0d icode=%0d wE=%b wM=%b required 2a/3/6/1/0",
                     W_valE, W_dstE, W_icode, wE_en, wM_en);
        end
    endtask

    task automatic test_load_error();
        pulse_reset();
        drive_m(STAT_AOK, I_MRMOVQ, 64'h100, 64'hDEAD, RNONE, 4'd2, 1'b1, 1'b1);
        #1;
        checks++;
        if (m_stat !== STAT_ADR) begin
            failures++;
            $display("FAIL load_err_mstat: got %0d required 3", m_stat);
        end
        tick();
        checks++;
        if (W_stat !== STAT_ADR || wM_en !== 1'b0 || wE_en !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL load_err_w: stat=%0d wM=%b halted=%b required 3/0/0", W_stat, wM_en, halted);
        end
        drive_m(STAT_AOK, I_OPQ, 64'h99, 64'h1, 4'd6, 4'd7, 1'b1, 1'b0);
        tick();
        checks++;
        if (halted !== 1'b1 || W_stat !== STAT_ADR || W_icode !== I_MRMOVQ || W_dstM !== 4'd2) begin
            failures++;
            $display("FAIL load_err_halt: halted=%b stat=%0d icode=%0d dstM=%0d required 1/3/5/2",
                     halted, W_stat, W_icode, W_dstM);
        end
        tick();
        checks++;
        if (W_icode !== I_MRMOVQ || W_valE !== 64'h100 || wE_en !== 1'b0 || wM_en !== 1'b0) begin
            failures++;
            $display("FAIL load_err_frozen: icode=%0d valE=%h wE=%b wM=%b required 5/100/0/0",
                     W_icode, W_valE, wE_en, wM_en);
        end
    endtask

    task automatic test_halt();
        pulse_reset();
        drive_m(STAT_HLT, I_HALT, '0, '0, RNONE, RNONE, 1'b1, 1'b0);
        tick();
        checks++;
        if (W_stat !== STAT_HLT || wE_en !== 1'b0 || wM_en !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_w: stat=%0d wE=%b wM=%b halted=%b required 2/0/0/0",
                     W_stat, wE_en, wM_en, halted);
        end
        drive_m(STAT_AOK, I_OPQ, 64'h5, 64'h6, 4'd1, 4'd1, 1'b1, 1'b0);
        tick();
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_flag: got %b required 1", halted);
        end
        W_bubble = 1'b1;
        tick();
        W_bubble = 1'b0;
        W_stall = 1'b1;
        tick();
        W_stall = 1'b0;
        tick();
        checks++;
        if (W_icode !== I_HALT || W_stat !== STAT_HLT || halted !== 1'b1 || wE_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_sticky: icode=%0d stat=%0d halted=%b wE=%b required 0/2/1/0",
                     W_icode, W_stat, halted, wE_en);
        end
    endtask

    task automatic test_stall_bubble();
        pulse_reset();
        drive_m(STAT_AOK, I_POPQ, 64'h10, 64'h20, 4'd4, 4'd5, 1'b1, 1'b0);
        tick();
        checks++;
        if (wE_en !== 1'b1 || wM_en !== 1'b1 || W_valM !== 64'h20 || W_dstM !== 4'd5) begin
            failures++;
            $display("FAIL popq_load: wE=%b wM=%b valM=%h dstM=%0d required 1/1/20/5",
                     wE_en, wM_en, W_valM, W_dstM);
        end
        drive_m(STAT_AOK, I_OPQ, 64'hAB, 64'hCD, 4'd8, 4'd9, 1'b1, 1'b0);
        W_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (W_icode !== I_POPQ || W_valE !== 64'h10 || W_dstE !== 4'd4 || W_dstM !== 4'd5) begin
                failures++;
                $display("FAIL stall_hold: icode=%0d valE=%h dstE=%0d required b/10/4", W_icode, W_valE, W_dstE);
            end
        end
        W_stall = 1'b0;
        W_bubble = 1'b1;
        tick();
        W_bubble = 1'b0;
        checks++;
        if (W_icode !== I_NOP || W_dstE !== RNONE || W_dstM !== RNONE || wE_en !== 1'b0 || wM_en !== 1'b0) begin
            failures++;
            $display("FAIL bubble_load: icode=%0d dstE=%h dstM=%h wE=%b wM=%b required 1/f/f/0/0",
                     W_icode, W_dstE, W_dstM, wE_en, wM_en);
        end
    endtask

    task automatic test_random();
        logic ev_e;
        logic ev_m;
        pulse_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 80 == 79) pulse_reset();
            M_stat     = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : STAT_AOK;
            dmem_error = ($urandom_range(0, 39) == 0);
            M_icode    = 4'($urandom_range(0, 11));
            M_valE     = {$urandom, $urandom};
            m_valM     = {$urandom, $urandom};
            M_dstE     = 4'($urandom_range(0, 15));
            M_dstM     = 4'($urandom_range(0, 15));
            M_valid    = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 5))
                0:       begin W_stall = 1'b1; W_bubble = 1'b0; end
                1:       begin W_stall = 1'b0; W_bubble = 1'b1; end
                default: begin W_stall = 1'b0; W_bubble = 1'b0; end
            endcase
            #1;
            checks++;
            if (m_stat !== (dmem_error ? STAT_ADR : M_stat)) begin
                failures++;
                $display("FAIL rand_mstat cyc=%0d: got %0d err=%b M_stat=%0d", cyc, m_stat, dmem_error, M_stat);
            end
            tick();
            ev_e = exp_w.valid && exp_w.stat == STAT_AOK && exp_w.dst_e != RNONE && !exp_halted;
            ev_m = exp_w.valid && exp_w.stat == STAT_AOK && exp_w.dst_m != RNONE && !exp_halted;
            checks++;
            if (W_stat !== exp_w.stat || W_icode !== exp_w.icode || W_valE !== exp_w.val_e ||
                W_valM !== exp_w.val_m || W_dstE !== exp_w.dst_e || W_dstM !== exp_w.dst_m ||
                wE_en !== ev_e || wM_en !== ev_m || halted !== exp_halted) begin
                failures++;
                $display("FAIL rand_w cyc=%0d: got stat=%0d ic=%0d dE=%h dM=%h wE=%b wM=%b h=%b required stat=%0d ic=%0d dE=%h dM=%h wE=%b wM=%b h=%b",
                         cyc, W_stat, W_icode, W_dstE, W_dstM, wE_en, wM_en, halted,
                         exp_w.stat, exp_w.icode, exp_w.dst_e, exp_w.dst_m, ev_e, ev_m, exp_halted);
            end
`ifdef RETIRE_CNT_EN
            checks++;
            if (int'(retired) !== exp_retired) begin
                failures++;
                $display("FAIL rand_retired cyc=%0d: got %0d required %0d", cyc, retired, exp_retired);
            end
`endif
        end
        W_stall = 1'b0;
        W_bubble = 1'b0;
    endtask

`ifdef RETIRE_CNT_EN
    task automatic test_retire_wrap();
        pulse_reset();
        drive_m(STAT_AOK, I_OPQ, 64'h1, 64'h2, 4'd1, RNONE, 1'b1, 1'b0);
        // 20 edges: 2 bubbles + 1 stall leave 17 retirements, which wraps a 4-bit count to 1.
        for (int i = 0; i < 20; i++) begin
            W_bubble = (i == 5 || i == 11);
            W_stall  = (i == 8);
            M_valE   = 64'(i);
            tick();
        end
        W_bubble = 1'b0;
        W_stall = 1'b0;
        checks++;
        if (retired !== 4'd1) begin
            failures++;
            $display("FAIL retire_wrap: got %0d required 1", retired);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_opq();
        test_load_error();
        test_halt();
        test_stall_bubble();
`ifdef RETIRE_CNT_EN
        test_retire_wrap();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
